gemm_tile_sequencer: RTL and testbench
======================================

Name: gemm_tile_sequencer

Overview:
Parametrised GEMM sequencer for an ARRAY_DIM x ARRAY_DIM output-stationary systolic array. It accepts a job (M, K, N, base addresses, accumulate mode) over a start/ready handshake. It tiles the output over M and N and streams A/B operand words from SRAM into the array. It then drains each tile and writes C rows back, suppressing rows beyond M for partial tiles. It sits between the host command interface and the A/B/C SRAMs plus the systolic array.

Parameters:
ARRAY_DIM, 4, systolic rows = columns; elements per A/B word and per C row.
DIM_WIDTH, 8, width of M/K/N fields.
ADDR_WIDTH, 16, SRAM address width.
ELEM_WIDTH, 8, A/B element width.
ACC_WIDTH, 32, C element (accumulator) width.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  job request; accepted when start && ready
ready  out  1  high only in IDLE
cfg_m, cfg_k, cfg_n  in  DIM_WIDTH each  matrix dimensions; latched on accept
cfg_base_a, cfg_base_b, cfg_base_c  in  ADDR_WIDTH each  SRAM base addresses; latched on accept
cfg_acc  in  1  1 = accumulate into array (no clear at tile start); latched on accept
abort  in  1  synchronous abort
rd_en_a, rd_en_b  out  1 each  SRAM read strobes; data valid next cycle
rd_addr_a, rd_addr_b  out  ADDR_WIDTH each  read addresses
arr_clear  out  1  clear array accumulators
arr_feed_valid  out  1  A/B SRAM data on bus is valid for the array (rd_en delayed one cycle)
arr_row_sel  out  clog2(ARRAY_DIM)  array row presented on arr_row_data
arr_row_data  in  ARRAY_DIM*ACC_WIDTH  selected accumulator row
wr_en_c  out  1  C write strobe
wr_addr_c  out  ADDR_WIDTH  C write address
wr_data_c  out  ARRAY_DIM*ACC_WIDTH  C write data
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at job completion
err  out  1  one-cycle pulse on rejected job

Behaviour:
- Reset: state IDLE, ready=1; every other output 0; counters and latched config 0.
- Tiling: TM = ceil(M/ARRAY_DIM), TN = ceil(N/ARRAY_DIM).
  - Tile order is m-tile outer, n-tile inner.
  - Indices mt, nt; step counter k; row counter r.
- Accept with any of M, K, N == 0: err=1 for the following cycle, stay in IDLE with ready=1, done never asserted.
- States:
  - IDLE: on valid accept -> CLEAR if cfg_acc=0, else -> FEED.
  - CLEAR: 1 cycle, arr_clear=1 -> FEED.
  - FEED: K cycles, k=0..K-1.
    - rd_en_a = rd_en_b = 1.
    - rd_addr_a = base_a + mt*K + k.
    - rd_addr_b = base_b + nt*K + k.
    - After k=K-1 -> DRAIN.
  - DRAIN: 2*ARRAY_DIM cycles, covering read latency and array skew -> STORE.
  - STORE: ARRAY_DIM cycles, r=0..ARRAY_DIM-1.
    - arr_row_sel=r.
    - wr_data_c = arr_row_data, combinational passthrough.
    - wr_addr_c = base_c + (mt*ARRAY_DIM + r)*TN + nt.
    - wr_en_c=1 only if mt*ARRAY_DIM + r < M.
    - -> NEXT.
  - NEXT: 1 cycle.
    - If nt<TN-1: nt++.
    - Else if mt<TM-1: nt=0, mt++.
    - Else -> DONE.
    - When not going to DONE -> CLEAR (cfg_acc=0) or FEED (cfg_acc=1).
  - DONE: done=1 for 1 cycle -> IDLE.
- arr_feed_valid equals rd_en_a registered one cycle; it is forced 0 after abort/reset.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent. Internal products use at least 2*DIM_WIDTH bits.
- Abort (any non-IDLE state):
  - Next cycle IDLE; all strobes 0; no done, no err.
  - A write in the abort cycle itself still occurs.
- start while busy is ignored. Config inputs are ignored except on the accept cycle.
- Async reset mid-job returns immediately to reset values.
- Per-tile cycles: (cfg_acc ? 0 : 1) + K + 2*ARRAY_DIM + ARRAY_DIM + 1. done follows the last tile's NEXT.

Test Plan:
1. ARRAY_DIM=4, M=K=N=4, acc=0, bases 0/0x100/0x200, accept edge E0.
   - CLEAR in cycle 1; FEED cycles 2-5 with rd_addr_a 0..3 and rd_addr_b 0x100..0x103.
   - arr_feed_valid cycles 3-6; DRAIN 6-13.
   - STORE 14-17 with wr_addr_c 0x200..0x203; NEXT 18; done=1 in cycle 19 only.
2. M=6, N=5, K=3 (TM=TN=2).
   - Four tiles, in order (0,0),(0,1),(1,0),(1,1).
   - Exactly 12 C writes; rows 6,7 are never written.
   - Row 5 of tile (1,1) goes to wr_addr_c = base_c + 5*2 + 1.
3. cfg_acc=1, M=K=N=4: arr_clear never asserted; done in cycle 18 after E0.
4. Accept with K=0: err=1 for exactly one cycle; no rd_en/wr_en; ready stays 1; done stays 0.
5. abort asserted in cycle 4 of test 1 → cycle 5 IDLE, ready=1, all strobes 0, no done. An immediate new start is accepted.
6. reset_n pulsed low during STORE → outputs return to reset values asynchronously; start pulsed while busy in test 1 → ignored, single done.

Source files
------------

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer
// Sequences one GEMM job over an ARRAY_DIM x ARRAY_DIM output-stationary
// systolic array. The output matrix is walked tile by tile (m-tile outer,
// n-tile inner). For each tile the sequencer optionally clears the array,
// streams K operand words from the A and B SRAMs and waits for the array to
// settle. It then reads the accumulator rows out one at a time and writes them
// to the C SRAM, dropping rows that lie beyond M.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   start / ready                      job handshake (accept = start && ready)
//   cfg_m/k/n, cfg_base_a/b/c, cfg_acc job description, latched on accept
//   abort                              synchronous abort back to IDLE
//   rd_en_a/b, rd_addr_a/b             A/B SRAM reads (data valid next cycle)
//   arr_clear, arr_feed_valid          array accumulator clear / operand valid
//   arr_row_sel, arr_row_data          accumulator row readout
//   wr_en_c, wr_addr_c, wr_data_c      C SRAM write port
//   busy, done, err                    status: active, completion, rejected job
module gemm_tile_sequencer #(
    parameter int ARRAY_DIM  = 4,
    parameter int DIM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int ELEM_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    localparam int RSW       = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    output logic                            ready,
    input  logic [DIM_WIDTH-1:0]            cfg_m,
    input  logic [DIM_WIDTH-1:0]            cfg_k,
    input  logic [DIM_WIDTH-1:0]            cfg_n,
    input  logic [ADDR_WIDTH-1:0]           cfg_base_a,
    input  logic [ADDR_WIDTH-1:0]           cfg_base_b,
    input  logic [ADDR_WIDTH-1:0]           cfg_base_c,
    input  logic                            cfg_acc,
    input  logic                            abort,
    output logic                            rd_en_a,
    output logic                            rd_en_b,
    output logic [ADDR_WIDTH-1:0]           rd_addr_a,
    output logic [ADDR_WIDTH-1:0]           rd_addr_b,
    output logic                            arr_clear,
    output logic                            arr_feed_valid,
    output logic [RSW-1:0]                  arr_row_sel,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0]  arr_row_data,
    output logic                            wr_en_c,
    output logic [ADDR_WIDTH-1:0]           wr_addr_c,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0]  wr_data_c,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int DW1 = DIM_WIDTH + 1;
    localparam int DSW = $clog2(2 * ARRAY_DIM);
    // Wide enough that no product or row index overflows before the final
    // modulo-2^ADDR_WIDTH truncation.
    localparam int PW  = 2 * DIM_WIDTH + RSW + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_STORE, S_NEXT, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [DIM_WIDTH-1:0]  m_lat, k_lat, n_lat;
    logic [ADDR_WIDTH-1:0] base_a_lat, base_b_lat, base_c_lat;
    logic                  acc_lat;

    logic [DIM_WIDTH-1:0]  mt, nt, kc;
    logic [DSW-1:0]        dc;
    logic [RSW-1:0]        rc;

    logic                  feed_vld_p1;
    logic                  err_q;

    logic                  zero_dim;
    logic [DW1-1:0]        tm_w, tn_w;
    logic                  mt_last, nt_last;
    logic [PW-1:0]         prod_a, prod_b, row_idx, prod_c;
    logic                  row_valid;

    assign zero_dim = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);

    // Tile counts: ceil(dim / ARRAY_DIM).
    assign tm_w = ({1'b0, m_lat} + DW1'(ARRAY_DIM - 1)) / DW1'(ARRAY_DIM);
    assign tn_w = ({1'b0, n_lat} + DW1'(ARRAY_DIM - 1)) / DW1'(ARRAY_DIM);
    assign mt_last = (({1'b0, mt} + DW1'(1)) == tm_w);
    assign nt_last = (({1'b0, nt} + DW1'(1)) == tn_w);

    assign prod_a    = PW'(mt) * PW'(k_lat) + PW'(kc);
    assign prod_b    = PW'(nt) * PW'(k_lat) + PW'(kc);
    assign row_idx   = PW'(mt) * PW'(ARRAY_DIM) + PW'(rc);
    assign prod_c    = row_idx * PW'(tn_w) + PW'(nt);
    assign row_valid = (row_idx < PW'(m_lat));

    assign arr_feed_valid = feed_vld_p1;
    assign err            = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        ready       = 1'b0;
        busy        = (state != S_IDLE);
        rd_en_a     = 1'b0;
        rd_en_b     = 1'b0;
        rd_addr_a   = '0;
        rd_addr_b   = '0;
        arr_clear   = 1'b0;
        arr_row_sel = '0;
        wr_en_c     = 1'b0;
        wr_addr_c   = '0;
        wr_data_c   = '0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start && !zero_dim) state_nx = cfg_acc ? S_FEED : S_CLEAR;
            end
            S_CLEAR: begin
                arr_clear = 1'b1;
                state_nx  = S_FEED;
            end
            S_FEED: begin
                rd_en_a   = 1'b1;
                rd_en_b   = 1'b1;
                rd_addr_a = base_a_lat + ADDR_WIDTH'(prod_a);
                rd_addr_b = base_b_lat + ADDR_WIDTH'(prod_b);
                if (kc == k_lat - DIM_WIDTH'(1)) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (dc == DSW'(2 * ARRAY_DIM - 1)) state_nx = S_STORE;
            end
            S_STORE: begin
                arr_row_sel = rc;
                wr_data_c   = arr_row_data;
                wr_addr_c   = base_c_lat + ADDR_WIDTH'(prod_c);
                wr_en_c     = row_valid;
                if (rc == RSW'(ARRAY_DIM - 1)) state_nx = S_NEXT;
            end
            S_NEXT: begin
                if (mt_last && nt_last) state_nx = S_DONE;
                else                    state_nx = acc_lat ? S_FEED : S_CLEAR;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_lat       <= '0;
            k_lat       <= '0;
            n_lat       <= '0;
            base_a_lat  <= '0;
            base_b_lat  <= '0;
            base_c_lat  <= '0;
            acc_lat     <= 1'b0;
            mt          <= '0;
            nt          <= '0;
            kc          <= '0;
            dc          <= '0;
            rc          <= '0;
            feed_vld_p1 <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // ---- operand valid: SRAM data appears one cycle after rd_en ----
            feed_vld_p1 <= rd_en_a && !abort;
            err_q       <= (state == S_IDLE) && start && zero_dim;

            if (state == S_IDLE && start && !zero_dim) begin
                m_lat      <= cfg_m;
                k_lat      <= cfg_k;
                n_lat      <= cfg_n;
                base_a_lat <= cfg_base_a;
                base_b_lat <= cfg_base_b;
                base_c_lat <= cfg_base_c;
                acc_lat    <= cfg_acc;
                mt         <= '0;
                nt         <= '0;
            end

            // Phase counters run only while their state persists, so each
            // phase starts from zero.
            kc <= (state == S_FEED  && state_nx == S_FEED)  ? kc + DIM_WIDTH'(1) : '0;
            dc <= (state == S_DRAIN && state_nx == S_DRAIN) ? dc + DSW'(1)       : '0;
            rc <= (state == S_STORE && state_nx == S_STORE) ? rc + RSW'(1)       : '0;

            if (state == S_NEXT && !abort) begin
                if (!nt_last) begin
                    nt <= nt + DIM_WIDTH'(1);
                end else if (!mt_last) begin
                    nt <= '0;
                    mt <= mt + DIM_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer. A model pushes the expected read
// address pairs and C writes for each accepted job into queues; a negedge
// monitor pops and compares them as the DUT issues reads and writes.
module tb_gemm_tile_sequencer;

    localparam int AD = 4;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int EW = 8;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              cfg_acc = 1'b0;
    logic [DW-1:0]     cfg_m = '0, cfg_k = '0, cfg_n = '0;
    logic [AW-1:0]     cfg_base_a = '0, cfg_base_b = '0, cfg_base_c = '0;
    logic              ready, rd_en_a, rd_en_b, arr_clear, arr_feed_valid;
    logic              wr_en_c, busy, done, err;
    logic [AW-1:0]     rd_addr_a, rd_addr_b, wr_addr_c;
    logic [1:0]        arr_row_sel;
    logic [AD*CW-1:0]  arr_row_data, wr_data_c;

    gemm_tile_sequencer #(
        .ARRAY_DIM(AD), .DIM_WIDTH(DW), .ADDR_WIDTH(AW),
        .ELEM_WIDTH(EW), .ACC_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ready(ready),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b), .cfg_base_c(cfg_base_c),
        .cfg_acc(cfg_acc), .abort(abort),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .arr_clear(arr_clear), .arr_feed_valid(arr_feed_valid),
        .arr_row_sel(arr_row_sel), .arr_row_data(arr_row_data),
        .wr_en_c(wr_en_c), .wr_addr_c(wr_addr_c), .wr_data_c(wr_data_c),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Array model: each row carries a distinct recognisable pattern.
    function automatic logic [AD*CW-1:0] row_val(int sel);
        logic [AD*CW-1:0] v;
        v = '0;
        for (int j = 0; j < AD; j++) v[j*CW +: CW] = 32'hC0DE_0000 + 32'(sel * 16 + j);
        return v;
    endfunction

    always_comb arr_row_data = row_val(int'(arr_row_sel));

    logic [AW-1:0]    rdq_a[$], rdq_b[$], wrq_addr[$];
    logic [AD*CW-1:0] wrq_data[$];
    int pass_cnt = 0, total_cnt = 0;
    int done_cnt = 0, clr_cnt = 0, err_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    logic [AW-1:0] last_wr_addr = '0;
    int cur = 0;

    task automatic chk(string tag, logic [AD*CW-1:0] obs, logic [AD*CW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (done)      done_cnt++;
            if (arr_clear) clr_cnt++;
            if (err)       err_cnt++;
            if (rd_en_a || rd_en_b) begin
                rd_cnt++;
                chk("rd_expected", rdq_a.size() > 0, 1'b1);
                chk("rd_en_b_pair", rd_en_b, rd_en_a);
                if (rdq_a.size() > 0) begin
                    chk("rd_addr_a", rd_addr_a, rdq_a.pop_front());
                    chk("rd_addr_b", rd_addr_b, rdq_b.pop_front());
                end
            end
            if (wr_en_c) begin
                wr_cnt++;
                last_wr_addr = wr_addr_c;
                chk("wr_expected", wrq_addr.size() > 0, 1'b1);
                if (wrq_addr.size() > 0) begin
                    chk("wr_addr_c", wr_addr_c, wrq_addr.pop_front());
                    chk("wr_data_c", wr_data_c, wrq_data.pop_front());
                end
            end
        end
    end

    task automatic push_model(int m, int k, int n, int ba, int bb, int bc);
        int tm, tn;
        if (m == 0 || k == 0 || n == 0) return;
        tm = (m + AD - 1) / AD;
        tn = (n + AD - 1) / AD;
        for (int mt = 0; mt < tm; mt++)
            for (int nt = 0; nt < tn; nt++) begin
                for (int kk = 0; kk < k; kk++) begin
                    rdq_a.push_back(AW'(ba + mt * k + kk));
                    rdq_b.push_back(AW'(bb + nt * k + kk));
                end
                for (int r = 0; r < AD; r++)
                    if (mt * AD + r < m) begin
                        wrq_addr.push_back(AW'(bc + (mt * AD + r) * tn + nt));
                        wrq_data.push_back(row_val(r));
                    end
            end
    endtask

    // Drives a job; returns at #1 into cycle 1 (the cycle after accept edge E0).
    task automatic apply_job(int m, int k, int n, int ba, int bb, int bc, logic acc);
        cfg_m = DW'(m); cfg_k = DW'(k); cfg_n = DW'(n);
        cfg_base_a = AW'(ba); cfg_base_b = AW'(bb); cfg_base_c = AW'(bc);
        cfg_acc = acc;
        push_model(m, k, n, ba, bb, bc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cur = 1;
    endtask

    task automatic to(int c);
        repeat (c - cur) @(posedge clk);
        #1;
        cur = c;
    endtask

    task automatic wait_ready(string tag);
        int n = 0;
        while (!ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, n < 500, 1'b1);
    endtask

    task automatic flush_queues();
        rdq_a.delete(); rdq_b.delete(); wrq_addr.delete(); wrq_data.delete();
    endtask

    int d0, w0, r0, c0, e0;

    initial begin
        // ---- reset values ----
        #12;
        chk("rst_ready", ready, 1'b1);
        chk("rst_strobes", {busy, rd_en_a, rd_en_b, arr_clear, arr_feed_valid, wr_en_c, done, err}, 8'h00);
        chk("rst_addrs", {rd_addr_a, rd_addr_b, wr_addr_c, arr_row_sel}, '0);
        chk("rst_wdata", wr_data_c, '0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // ---- test 1: single 4x4x4 tile, plus start while busy ----
        d0 = done_cnt;
        apply_job(4, 4, 4, 0, 'h100, 'h200, 1'b0);
        chk("t1_c1_clear", {arr_clear, busy, ready}, 3'b110);
        to(2);
        chk("t1_c2_feed", {rd_en_a, rd_addr_a, rd_addr_b, arr_feed_valid}, {1'b1, 16'h0, 16'h100, 1'b0});
        to(3);
        chk("t1_c3_fv", {arr_feed_valid, rd_addr_a}, {1'b1, 16'h1});
        to(5);
        chk("t1_c5_addr", {rd_addr_a, rd_addr_b}, {16'h3, 16'h103});
        to(6);
        chk("t1_c6_drain", {rd_en_a, arr_feed_valid}, 2'b01);
        to(7);
        chk("t1_c7_fv", arr_feed_valid, 1'b0);
        to(8);
        start = 1'b1; cfg_m = 8'd1; cfg_k = 8'd1; cfg_n = 8'd1; cfg_acc = 1'b1;
        to(9);
        start = 1'b0;
        chk("t1_busy_start", {busy, ready}, 2'b10);
        to(13);
        chk("t1_c13_nowr", wr_en_c, 1'b0);
        to(14);
        chk("t1_c14_store", {wr_en_c, wr_addr_c, arr_row_sel}, {1'b1, 16'h200, 2'd0});
        to(17);
        chk("t1_c17_store", {wr_en_c, wr_addr_c, arr_row_sel}, {1'b1, 16'h203, 2'd3});
        to(18);
        chk("t1_c18_next", {wr_en_c, done}, 2'b00);
        to(19);
        chk("t1_c19_done", done, 1'b1);
        to(20);
        chk("t1_c20_idle", {done, ready, busy}, 3'b010);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_q_empty", rdq_a.size() + wrq_addr.size(), 0);

        // ---- test 2: partial tiles M=6 K=3 N=5 ----
        d0 = done_cnt; w0 = wr_cnt;
        apply_job(6, 3, 5, 'h10, 'h40, 'h300, 1'b0);
        wait_ready("t2_timeout");
        chk("t2_wr_count", wr_cnt - w0, 12);
        chk("t2_last_addr", last_wr_addr, 16'h300 + 16'd11);
        chk("t2_done_once", done_cnt - d0, 1);
        chk("t2_q_empty", rdq_a.size() + wrq_addr.size(), 0);

        // ---- test 3: accumulate mode, no clear ----
        d0 = done_cnt; c0 = clr_cnt;
        apply_job(4, 4, 4, 'h20, 'h60, 'h500, 1'b1);
        chk("t3_c1_feed", {arr_clear, rd_en_a, rd_addr_a}, {1'b0, 1'b1, 16'h20});
        to(17);
        chk("t3_c17_nodone", done, 1'b0);
        to(18);
        chk("t3_c18_done", done, 1'b1);
        to(19);
        chk("t3_c19_idle", ready, 1'b1);
        chk("t3_no_clear", clr_cnt - c0, 0);
        chk("t3_q_empty", rdq_a.size() + wrq_addr.size(), 0);

        // ---- test 4: K=0 rejected ----
        d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        apply_job(4, 0, 4, 0, 'h100, 'h200, 1'b0);
        chk("t4_c1_err", {err, ready, busy}, 3'b110);
        to(2);
        chk("t4_c2_err", {err, ready}, 2'b01);
        to(5);
        chk("t4_no_traffic", (rd_cnt - r0) + (wr_cnt - w0) + (done_cnt - d0), 0);
        chk("t4_err_once", err_cnt - e0, 1);

        // ---- test 5: abort during FEED, then immediate restart ----
        d0 = done_cnt;
        apply_job(4, 4, 4, 0, 'h100, 'h200, 1'b0);
        to(4);
        chk("t5_c4_feed", {rd_en_a, rd_addr_a}, {1'b1, 16'h2});
        abort = 1'b1;
        to(5);
        abort = 1'b0;
        chk("t5_c5_idle", {ready, busy}, 2'b10);
        chk("t5_c5_strobes", {rd_en_a, rd_en_b, arr_feed_valid, wr_en_c, arr_clear, done, err}, 7'h00);
        flush_queues();
        apply_job(4, 4, 4, 'h30, 'h130, 'h230, 1'b1);
        chk("t5_restart", {busy, rd_en_a, rd_addr_a}, {1'b1, 1'b1, 16'h30});
        wait_ready("t5_timeout");
        chk("t5_done_once", done_cnt - d0, 1);
        chk("t5_q_empty", rdq_a.size() + wrq_addr.size(), 0);

        // ---- test 6: async reset in STORE ----
        apply_job(4, 4, 4, 0, 'h100, 'h200, 1'b0);
        to(15);
        chk("t6_in_store", {wr_en_c, arr_row_sel}, {1'b1, 2'd1});
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", {ready, busy, wr_en_c, rd_en_a, arr_feed_valid, done, err}, 7'b1000000);
        chk("t6_rst_data", {wr_addr_c, arr_row_sel, rd_addr_a}, '0);
        chk("t6_rst_wdata", wr_data_c, '0);
        flush_queues();
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_post_rst", {ready, done}, 2'b10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
